incdec_sequencer: RTL and testbench
===================================

# incdec_sequencer

Sequential microcode engine for the INC/DEC instruction family: 8-bit register, (HL) read-modify-write and 16-bit register-pair forms, across one or more M-cycles. It sits in the control unit beside the other per-family microcode blocks. It owns its own T-step and M-cycle counters, and drives the standard datapath control bundle that the control-unit OR-merge consumes. It replaces the per-form combinational decode with one parametrised, self-timed block with start/done handshaking.

## Interface
- STEPS_PER_MCYCLE, 4, T-steps per M-cycle; legal values are 4 or more.
- ADDR_STEP, 1, step index for address drive.
- ALU_STEP, 2, step index for ALU/IDU operation; bus transfer uses step STEPS_PER_MCYCLE-1.
- i_Clk  in  1  sole clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Step_Enable  in  1  T-step advance qualifier; all control outputs are gated by it.
- i_Start  in  1  launch request; sampled when idle or when o_Done is high.
- i_Opcode  in  8  opcode captured on accepted start.
- o_Busy  out  1  high from accepted start through the o_Done cycle.
- o_Done  out  1  one-cycle pulse on the final qualified step.
- o_Illegal  out  1  one-cycle pulse when a start carries a non-INC/DEC opcode.
- o_IR_Fetch  out  1  opcode prefetch, asserted on the final step.
- o_Read8, o_Write8  out  8 each  one-hot; [7:2]=B,C,D,E,H,L, [1]=Z latch, [0]=A.
- o_Read16  out  6  one-hot; [0]=PC, [1]=SP, [2]=WZ, [3]=HL, [4]=DE, [5]=BC.
- o_ReadALU8, o_WriteALU8  out  2 each  [0]=ALU operand/result latch, [1] is tied 0.
- o_IDU_Control  out  2  [0]=inc, [1]=dec, on the 16-bit path; no flags.
- o_Move_Reg, o_Bus_In, o_Bus_Out, o_Address_Out  out  1 each  datapath strobes.
- o_ALU_Control  out  7  [6]=enable, [5:3]=000 (add), [2]=subtract, [1]=constant-one operand, [0]=0.

## Operation
- Decode on accepted start:
  - 00rrr10d with rrr≠110 → R8 mode.
  - 00110 10d → HL mode.
  - 00pp d011 → R16 mode.
  - d=1 selects decrement. Pairs: pp=00 BC, 01 DE, 10 HL, 11 SP.
  - Any other opcode → o_Illegal pulse; the block stays IDLE.
- States: IDLE and RUN. Latched context: mode, register select, direction, step counter, M-cycle counter.
- R8 (1 M-cycle):
  - ALU_STEP: Read8/Write8[reg], ALU_Control = enable + constant-one, with subtract = d.
- R16 (2 M-cycles):
  - M0 ALU_STEP: Read16[pair] and o_IDU_Control = d ? 10 : 01. Writeback to the pair is implicit in the IDU.
  - M1: idle steps, then prefetch.
- HL (3 M-cycles):
  - M0 ADDR_STEP: Read16[HL] + Address_Out.
  - M0 last step: Bus_In + Write8[Z].
  - M1 ALU_STEP: Read8[Z] + Write8[Z] + ALU op.
  - M2 ADDR_STEP: Read16[HL] + Address_Out.
  - M2 last step: Bus_Out + Read8[Z] + Move_Reg.
- The final step of the last M-cycle asserts o_IR_Fetch, o_Done, and clears RUN.

## Timing
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-instruction aborts immediately with no further strobes.
- Start latency: start accepted in cycle N → step 0 of M0 is in cycle N+1.
- Counters advance only in cycles where i_Step_Enable is high. Step counter wraps STEPS_PER_MCYCLE-1 → 0 and increments the M-cycle counter.
- With i_Step_Enable low: state holds and all strobes are 0; o_Busy stays high.
- Back-to-back: start during o_Done → the next step 0 follows with no gap.
- i_Start during RUN (outside o_Done) is ignored.
- Start with an illegal opcode: o_Illegal is high in cycle N+1; o_Busy never rises.
- Unstalled durations: R8 = STEPS, R16 = 2×STEPS, HL = 3×STEPS cycles from first step through o_Done.

## Structure
- Shared package holds: mode enum (R8, HL, R16), one-hot index constants for the Read8/Read16 maps, ALU_Control field constants, opcode mask constants.
- One natural sub-module, incdec_opcode_decode: combinational opcode → {legal, mode, one-hot reg, pair, dir}.

## Test plan
- INC B (0x04), enable tied high:
  - cycle N+3: Read8=Write8=0x80, ALU_Control=0x42.
  - cycle N+4: o_IR_Fetch + o_Done.
- DEC (HL) (0x35):
  - Address_Out at steps 1/9, Bus_In at step 3, ALU_Control=0x46 at step 6, Bus_Out + Move_Reg at step 11.
  - o_Done at step 11; o_Busy spans 12 cycles.
- INC SP (0x33): Read16=0x02 and IDU=01 at step 2; o_Done at step 7; ALU_Control stays 0.
- Stall: DEC C (0x0D) with i_Step_Enable low for 5 cycles after step 1 → no strobes while low; ALU pulse occurs on the next enabled cycle.
- Reset at HL step 5 → all outputs 0 next cycle, IDLE. A subsequent INC A (0x3C) completes normally.
- Start 0x00 → o_Illegal pulse only. Start INC B during o_Done of a prior INC B → seamless second sequence.

Source files
------------

// File: rtl/incdec_sequencer_pkg.sv
// Shared definitions for the INC/DEC microcode sequencer: modes, one-hot
// register maps, ALU control fields and opcode match masks.
package incdec_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_R8,
    MODE_HL,
    MODE_R16
  } mode_e;

  // Read8/Write8 one-hot map
  localparam logic [7:0] R8_OH_B = 8'b1000_0000;
  localparam logic [7:0] R8_OH_C = 8'b0100_0000;
  localparam logic [7:0] R8_OH_D = 8'b0010_0000;
  localparam logic [7:0] R8_OH_E = 8'b0001_0000;
  localparam logic [7:0] R8_OH_H = 8'b0000_1000;
  localparam logic [7:0] R8_OH_L = 8'b0000_0100;
  localparam logic [7:0] R8_OH_Z = 8'b0000_0010;
  localparam logic [7:0] R8_OH_A = 8'b0000_0001;

  // Read16 one-hot map
  localparam logic [5:0] R16_OH_PC = 6'b00_0001;
  localparam logic [5:0] R16_OH_SP = 6'b00_0010;
  localparam logic [5:0] R16_OH_WZ = 6'b00_0100;
  localparam logic [5:0] R16_OH_HL = 6'b00_1000;
  localparam logic [5:0] R16_OH_DE = 6'b01_0000;
  localparam logic [5:0] R16_OH_BC = 6'b10_0000;

  localparam logic [6:0] ALU_EN  = 7'b100_0000;
  localparam logic [6:0] ALU_SUB = 7'b000_0100;
  localparam logic [6:0] ALU_ONE = 7'b000_0010;

  localparam logic [1:0] IDU_INC = 2'b01;
  localparam logic [1:0] IDU_DEC = 2'b10;

  localparam logic [7:0] OPC_HL_MASK   = 8'hFE;
  localparam logic [7:0] OPC_HL_MATCH  = 8'h34;
  localparam logic [7:0] OPC_R8_MASK   = 8'hC6;
  localparam logic [7:0] OPC_R8_MATCH  = 8'h04;
  localparam logic [7:0] OPC_R16_MASK  = 8'hC7;
  localparam logic [7:0] OPC_R16_MATCH = 8'h03;

endpackage

// File: rtl/incdec_sequencer_if.sv
// Handshake and datapath-control bundle of the INC/DEC sequencer.
interface incdec_sequencer_if;
  logic       i_Step_Enable;
  logic       i_Start;
  logic [7:0] i_Opcode;
  logic       o_Busy;
  logic       o_Done;
  logic       o_Illegal;
  logic       o_IR_Fetch;
  logic [7:0] o_Read8;
  logic [7:0] o_Write8;
  logic [5:0] o_Read16;
  logic [1:0] o_ReadALU8;
  logic [1:0] o_WriteALU8;
  logic [1:0] o_IDU_Control;
  logic       o_Move_Reg;
  logic       o_Bus_In;
  logic       o_Bus_Out;
  logic       o_Address_Out;
  logic [6:0] o_ALU_Control;

  modport master (
    output i_Step_Enable, i_Start, i_Opcode,
    input  o_Busy, o_Done, o_Illegal, o_IR_Fetch, o_Read8, o_Write8, o_Read16,
           o_ReadALU8, o_WriteALU8, o_IDU_Control, o_Move_Reg, o_Bus_In,
           o_Bus_Out, o_Address_Out, o_ALU_Control
  );

  modport slave (
    input  i_Step_Enable, i_Start, i_Opcode,
    output o_Busy, o_Done, o_Illegal, o_IR_Fetch, o_Read8, o_Write8, o_Read16,
           o_ReadALU8, o_WriteALU8, o_IDU_Control, o_Move_Reg, o_Bus_In,
           o_Bus_Out, o_Address_Out, o_ALU_Control
  );
endinterface

// File: rtl/incdec_opcode_decode.sv
// Combinational INC/DEC opcode classifier: legality, mode, operand select, direction.
module incdec_opcode_decode
  import incdec_sequencer_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       legal,
  output mode_e      mode,
  output logic [7:0] reg_oh,
  output logic [5:0] pair_oh,
  output logic       dir
);

  // 0x34/0x35 also match the R8 mask, so the HL form is tested first
  always_comb begin
    legal   = 1'b0;
    mode    = MODE_R8;
    reg_oh  = '0;
    pair_oh = '0;
    dir     = 1'b0;
    if ((opcode & OPC_HL_MASK) == OPC_HL_MATCH) begin
      legal = 1'b1;
      mode  = MODE_HL;
      dir   = opcode[0];
    end else if ((opcode & OPC_R8_MASK) == OPC_R8_MATCH) begin
      legal = 1'b1;
      mode  = MODE_R8;
      dir   = opcode[0];
      case (opcode[5:3])
        3'd0:    reg_oh = R8_OH_B;
        3'd1:    reg_oh = R8_OH_C;
        3'd2:    reg_oh = R8_OH_D;
        3'd3:    reg_oh = R8_OH_E;
        3'd4:    reg_oh = R8_OH_H;
        3'd5:    reg_oh = R8_OH_L;
        3'd7:    reg_oh = R8_OH_A;
        default: reg_oh = '0;
      endcase
    end else if ((opcode & OPC_R16_MASK) == OPC_R16_MATCH) begin
      legal = 1'b1;
      mode  = MODE_R16;
      dir   = opcode[3];
      case (opcode[5:4])
        2'd0:    pair_oh = R16_OH_BC;
        2'd1:    pair_oh = R16_OH_DE;
        2'd2:    pair_oh = R16_OH_HL;
        default: pair_oh = R16_OH_SP;
      endcase
    end
  end

endmodule

// File: rtl/incdec_sequencer.sv
// Self-timed INC/DEC microcode engine: owns T-step and M-cycle counters and
// drives the datapath control bundle for R8, (HL) and R16 forms.
module incdec_sequencer
  import incdec_sequencer_pkg::*;
#(
  parameter int unsigned STEPS_PER_MCYCLE = 4,
  parameter int unsigned ADDR_STEP        = 1,
  parameter int unsigned ALU_STEP         = 2
) (
  input logic                i_Clk,
  input logic                i_Reset,
  incdec_sequencer_if.slave  bus
);

  localparam int unsigned     STEP_W = $clog2(STEPS_PER_MCYCLE);
  localparam logic [STEP_W-1:0] LAST_T = STEP_W'(STEPS_PER_MCYCLE - 1);
  localparam logic [STEP_W-1:0] ADDR_T = STEP_W'(ADDR_STEP);
  localparam logic [STEP_W-1:0] ALU_T  = STEP_W'(ALU_STEP);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [7:0]        reg_q, reg_d;
  logic [5:0]        pair_q, pair_d;
  logic              dir_q, dir_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [1:0]        mcyc_q, mcyc_d;
  logic              illegal_q, illegal_d;

  logic       dec_legal, dec_dir;
  mode_e      dec_mode;
  logic [7:0] dec_reg;
  logic [5:0] dec_pair;

  logic       act, fin, accept;
  logic [1:0] last_mcyc;

  incdec_opcode_decode u_decode (
    .opcode  (bus.i_Opcode),
    .legal   (dec_legal),
    .mode    (dec_mode),
    .reg_oh  (dec_reg),
    .pair_oh (dec_pair),
    .dir     (dec_dir)
  );

  always_comb begin
    case (mode_q)
      MODE_R16: last_mcyc = 2'd1;
      MODE_HL:  last_mcyc = 2'd2;
      default:  last_mcyc = 2'd0;
    endcase
    act    = (state_q == ST_RUN) && bus.i_Step_Enable && !i_Reset;
    fin    = act && (mcyc_q == last_mcyc) && (step_q == LAST_T);
    accept = bus.i_Start && ((state_q == ST_IDLE) || fin);
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    reg_d     = reg_q;
    pair_d    = pair_q;
    dir_d     = dir_q;
    step_d    = step_q;
    mcyc_d    = mcyc_q;
    illegal_d = 1'b0;
    if (accept) begin
      step_d = '0;
      mcyc_d = '0;
      if (dec_legal) begin
        state_d = ST_RUN;
        mode_d  = dec_mode;
        reg_d   = dec_reg;
        pair_d  = dec_pair;
        dir_d   = dec_dir;
      end else begin
        state_d   = ST_IDLE;
        illegal_d = 1'b1;
      end
    end else if (fin) begin
      state_d = ST_IDLE;
      step_d  = '0;
      mcyc_d  = '0;
    end else if (act) begin
      if (step_q == LAST_T) begin
        step_d = '0;
        mcyc_d = mcyc_q + 2'd1;
      end else begin
        step_d = step_q + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_R8;
      reg_q     <= '0;
      pair_q    <= '0;
      dir_q     <= 1'b0;
      step_q    <= '0;
      mcyc_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      reg_q     <= reg_d;
      pair_q    <= pair_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      mcyc_q    <= mcyc_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes are decoded from the registered step and qualified by act,
  // so a stall or a reset cycle never leaks a strobe.
  always_comb begin
    bus.o_Busy        = (state_q == ST_RUN) && !i_Reset;
    bus.o_Illegal     = illegal_q && !i_Reset;
    bus.o_Done        = fin;
    bus.o_IR_Fetch    = fin;
    bus.o_Read8       = '0;
    bus.o_Write8      = '0;
    bus.o_Read16      = '0;
    bus.o_ReadALU8    = '0;
    bus.o_WriteALU8   = '0;
    bus.o_IDU_Control = '0;
    bus.o_Move_Reg    = 1'b0;
    bus.o_Bus_In      = 1'b0;
    bus.o_Bus_Out     = 1'b0;
    bus.o_Address_Out = 1'b0;
    bus.o_ALU_Control = '0;
    if (act) begin
      case (mode_q)
        MODE_R8: begin
          if (step_q == ALU_T) begin
            bus.o_Read8       = reg_q;
            bus.o_Write8      = reg_q;
            bus.o_ALU_Control = ALU_EN | ALU_ONE | (dir_q ? ALU_SUB : 7'h00);
          end
        end
        MODE_R16: begin
          if (mcyc_q == 2'd0 && step_q == ALU_T) begin
            bus.o_Read16      = pair_q;
            bus.o_IDU_Control = dir_q ? IDU_DEC : IDU_INC;
          end
        end
        default: begin
          if ((mcyc_q == 2'd0 || mcyc_q == 2'd2) && step_q == ADDR_T) begin
            bus.o_Read16      = R16_OH_HL;
            bus.o_Address_Out = 1'b1;
          end
          if (mcyc_q == 2'd0 && step_q == LAST_T) begin
            bus.o_Bus_In = 1'b1;
            bus.o_Write8 = R8_OH_Z;
          end
          if (mcyc_q == 2'd1 && step_q == ALU_T) begin
            bus.o_Read8       = R8_OH_Z;
            bus.o_Write8      = R8_OH_Z;
            bus.o_ALU_Control = ALU_EN | ALU_ONE | (dir_q ? ALU_SUB : 7'h00);
          end
          if (mcyc_q == 2'd2 && step_q == LAST_T) begin
            bus.o_Bus_Out  = 1'b1;
            bus.o_Read8    = R8_OH_Z;
            bus.o_Move_Reg = 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_incdec_sequencer.sv
// Bench for incdec_sequencer: vector table, directed multi-cycle sequences and
// a randomized run against a queue-based per-step reference model.
module tb_incdec_sequencer;

  localparam int unsigned S    = 4;
  localparam int unsigned ADDR = 1;
  localparam int unsigned ALU  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  incdec_sequencer_if bus ();

  incdec_sequencer #(
    .STEPS_PER_MCYCLE (S),
    .ADDR_STEP        (ADDR),
    .ALU_STEP         (ALU)
  ) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus.master)
  );

  typedef struct packed {
    logic       busy, done, illegal, irf;
    logic [7:0] r8, w8;
    logic [5:0] r16;
    logic [1:0] ralu, walu, idu;
    logic       mv, bin, bout, aout;
    logic [6:0] alu;
  } obs_t;

  typedef struct {
    bit         s;
    bit         en;
    logic [7:0] op;
    obs_t       exp;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  function automatic obs_t sample();
    obs_t o;
    o.busy = bus.o_Busy;        o.done = bus.o_Done;
    o.illegal = bus.o_Illegal;  o.irf = bus.o_IR_Fetch;
    o.r8 = bus.o_Read8;         o.w8 = bus.o_Write8;
    o.r16 = bus.o_Read16;       o.ralu = bus.o_ReadALU8;
    o.walu = bus.o_WriteALU8;   o.idu = bus.o_IDU_Control;
    o.mv = bus.o_Move_Reg;      o.bin = bus.o_Bus_In;
    o.bout = bus.o_Bus_Out;     o.aout = bus.o_Address_Out;
    o.alu = bus.o_ALU_Control;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t exp);
    obs_t got;
    got = sample();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // One clock cycle: inputs applied just after the edge, outputs observed at the falling edge.
  task automatic cyc(input bit s, input bit en, input logic [7:0] op, input bit r);
    @(posedge clk);
    #1;
    bus.i_Start       = s;
    bus.i_Step_Enable = en;
    bus.i_Opcode      = op;
    rst               = r;
    @(negedge clk);
  endtask

  // 0 = illegal, 1 = r8, 2 = (HL), 3 = r16
  function automatic int kind(input logic [7:0] op);
    if (op[7:6] != 2'b00) return 0;
    if (op[2:0] == 3'b011) return 3;
    if (op[2:1] == 2'b10) return (op[5:3] == 3'd6) ? 2 : 1;
    return 0;
  endfunction

  function automatic int unsigned seq_len(input logic [7:0] op);
    case (kind(op))
      1:       return S;
      3:       return 2 * S;
      2:       return 3 * S;
      default: return 0;
    endcase
  endfunction

  // Expected outputs on the k-th qualified step of an instruction.
  function automatic obs_t exp_step(input logic [7:0] op, input int unsigned k);
    obs_t        e;
    int unsigned m, t;
    logic [7:0]  rb;
    logic [5:0]  pr;
    logic [6:0]  aluv;
    int          kd;
    kd = kind(op);
    m  = k / S;
    t  = k % S;
    rb = (op[5:3] == 3'd7) ? 8'h01 : (8'h80 >> op[5:3]);
    case (op[5:4])
      2'd0:    pr = 6'h20;
      2'd1:    pr = 6'h10;
      2'd2:    pr = 6'h08;
      default: pr = 6'h02;
    endcase
    aluv = op[0] ? 7'h46 : 7'h42;
    e = '0;
    e.busy = 1'b1;
    if (kd == 1 && t == ALU) begin
      e.r8 = rb; e.w8 = rb; e.alu = aluv;
    end
    if (kd == 3 && m == 0 && t == ALU) begin
      e.r16 = pr; e.idu = op[3] ? 2'b10 : 2'b01;
    end
    if (kd == 2) begin
      if ((m == 0 || m == 2) && t == ADDR) begin e.r16 = 6'h08; e.aout = 1'b1; end
      if (m == 0 && t == S - 1) begin e.bin = 1'b1; e.w8 = 8'h02; end
      if (m == 1 && t == ALU) begin e.r8 = 8'h02; e.w8 = 8'h02; e.alu = aluv; end
      if (m == 2 && t == S - 1) begin e.bout = 1'b1; e.r8 = 8'h02; e.mv = 1'b1; end
    end
    if (k == seq_len(op) - 1) begin e.done = 1'b1; e.irf = 1'b1; end
    return e;
  endfunction

  function automatic obs_t busy_only();
    obs_t e;
    e = '0;
    e.busy = 1'b1;
    return e;
  endfunction

  function automatic obs_t r8o(input bit busy, input bit fin, input logic [7:0] rw,
                               input logic [6:0] aluv, input bit ill);
    obs_t e;
    e = '0;
    e.busy = busy; e.done = fin; e.irf = fin;
    e.r8 = rw; e.w8 = rw; e.alu = aluv; e.illegal = ill;
    return e;
  endfunction

  vec_t tbl [13];
  obs_t q [$];

  initial begin
    obs_t       e;
    bit         s, en, ill_pend, acc_ok;
    logic [7:0] op;
    int         busy_cnt, done_at;

    bus.i_Start = 1'b0; bus.i_Step_Enable = 1'b0; bus.i_Opcode = 8'h00;

    // INC B, ignored start mid-run, back-to-back INC B, illegal during done and from idle
    tbl[0]  = '{1'b1, 1'b1, 8'h04, r8o(0, 0, 8'h00, 7'h00, 0)};
    tbl[1]  = '{1'b0, 1'b1, 8'h00, r8o(1, 0, 8'h00, 7'h00, 0)};
    tbl[2]  = '{1'b1, 1'b1, 8'h05, r8o(1, 0, 8'h00, 7'h00, 0)};
    tbl[3]  = '{1'b0, 1'b1, 8'h00, r8o(1, 0, 8'h80, 7'h42, 0)};
    tbl[4]  = '{1'b1, 1'b1, 8'h04, r8o(1, 1, 8'h00, 7'h00, 0)};
    tbl[5]  = '{1'b0, 1'b1, 8'h00, r8o(1, 0, 8'h00, 7'h00, 0)};
    tbl[6]  = '{1'b1, 1'b1, 8'h0D, r8o(1, 0, 8'h00, 7'h00, 0)};
    tbl[7]  = '{1'b0, 1'b1, 8'h00, r8o(1, 0, 8'h80, 7'h42, 0)};
    tbl[8]  = '{1'b1, 1'b1, 8'h00, r8o(1, 1, 8'h00, 7'h00, 0)};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, r8o(0, 0, 8'h00, 7'h00, 1)};
    tbl[10] = '{1'b1, 1'b0, 8'h00, r8o(0, 0, 8'h00, 7'h00, 0)};
    tbl[11] = '{1'b0, 1'b1, 8'h00, r8o(0, 0, 8'h00, 7'h00, 1)};
    tbl[12] = '{1'b0, 1'b1, 8'h00, r8o(0, 0, 8'h00, 7'h00, 0)};

    cyc(0, 0, 8'h00, 1);
    cyc(0, 1, 8'h00, 1);
    check_obs("reset", '0);
    cyc(0, 1, 8'h00, 0);
    check_obs("post_reset", '0);

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].s, tbl[i].en, tbl[i].op, 0);
      check_obs($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // DEC (HL): full step trace, busy span and done position
    cyc(1, 1, 8'h35, 0);
    check_obs("hl_accept", '0);
    busy_cnt = 0; done_at = -1;
    for (int k = 0; k < 14; k++) begin
      cyc(0, 1, 8'h00, 0);
      if (bus.o_Busy) busy_cnt++;
      if (bus.o_Done) done_at = k;
      if (k < 12) check_obs($sformatf("hl_step%0d", k), exp_step(8'h35, k));
    end
    check_int("hl_busy_span", busy_cnt, 12);
    check_int("hl_done_step", done_at, 11);

    // INC SP
    cyc(1, 1, 8'h33, 0);
    done_at = -1;
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, 8'h00, 0);
      if (bus.o_Done) done_at = k;
      check_obs($sformatf("sp_step%0d", k), exp_step(8'h33, k));
    end
    check_int("sp_done_step", done_at, 7);

    // DEC C with a five-cycle stall after step 1
    cyc(1, 1, 8'h0D, 0);
    for (int k = 0; k < 2; k++) begin
      cyc(0, 1, 8'h00, 0);
      check_obs($sformatf("stall_pre%0d", k), exp_step(8'h0D, k));
    end
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 8'h00, 0);
      check_obs($sformatf("stall_low%0d", k), busy_only());
    end
    cyc(0, 1, 8'h00, 0);
    check_obs("stall_alu", r8o(1, 0, 8'h40, 7'h46, 0));
    cyc(0, 1, 8'h00, 0);
    check_obs("stall_done", exp_step(8'h0D, 3));

    // Reset while INC (HL) is at step 5, then INC A
    cyc(1, 1, 8'h34, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 8'h00, 0);
      check_obs($sformatf("rst_hl%0d", k), exp_step(8'h34, k));
    end
    cyc(0, 1, 8'h00, 1);
    cyc(0, 1, 8'h00, 0);
    check_obs("rst_abort0", '0);
    cyc(0, 1, 8'h00, 0);
    check_obs("rst_abort1", '0);
    cyc(1, 1, 8'h3C, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 8'h00, 0);
      check_obs($sformatf("inc_a%0d", k), exp_step(8'h3C, k));
    end
    cyc(0, 1, 8'h00, 0);
    check_obs("inc_a_idle", '0);

    // Randomized run against the step-queue model
    ill_pend = 1'b0;
    q.delete();
    for (int c = 0; c < 600; c++) begin
      s  = ($urandom_range(0, 3) == 0);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) op = 8'($urandom);
      else op = 8'($urandom_range(0, 63));
      cyc(s, en, op, 0);
      e = '0;
      if (q.size() > 0) e = en ? q[0] : busy_only();
      e.illegal = ill_pend;
      check_obs("rand", e);
      acc_ok = (q.size() == 0) || (en && q.size() == 1);
      if (en && q.size() > 0) void'(q.pop_front());
      ill_pend = 1'b0;
      if (s && acc_ok) begin
        if (kind(op) != 0) begin
          for (int k = 0; k < int'(seq_len(op)); k++) q.push_back(exp_step(op, k));
        end else begin
          ill_pend = 1'b1;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
